shift_seq: RTL and testbench

- Sequencing stage directly upstream of the combinational barrel shifter (`barrel`, parameter `width`).
- Accepts shift requests on a valid/ready handshake. Requests may carry counts larger than the barrel can perform in one pass.
- Decomposes each request into one or more barrel passes, feeding each pass result back as the next input.
- Holds the final result on a valid/ready response port.
- The parent instantiates `barrel` next to this block and wires the `b_*` ports to it.

---
 rtl/shift_seq.sv | 115 +++++++++++
 tb/tb_shift_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// Multi-pass sequencer in front of a single-pass barrel shifter: splits large
// shift counts into barrel-sized passes and returns the result on a valid/ready port.
module shift_seq #(
  parameter int WIDTH = 32,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_data,
  input  logic [CW-1:0]            req_count,
  input  logic                     req_left,
  input  logic [1:0]               req_type,
  output logic [WIDTH-1:0]         b_in,
  output logic [$clog2(WIDTH)-1:0] b_ct,
  output logic                     b_dir,
  output logic [1:0]               b_type,
  input  logic [WIDTH-1:0]         b_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [CW-1:0]            rsp_passes
);
  // state | meaning
  // IDLE  | waiting for a request (req_ready high)
  // SHIFT | one barrel pass per cycle until the remaining count is used up
  // HOLD  | result presented on the response port until taken
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] MAX_CT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]   rem;
  logic [CW-1:0]   passes;
  logic            dir_q;
  logic [1:0]      type_q;
  logic            wrap;
  logic [CW-1:0]   eff;
  logic [BW-1:0]   pass_ct;
  logic [CW-1:0]   rem_next;

  // Rotating types never need more than one pass, so their count is reduced mod WIDTH.
  always_comb begin
    wrap     = (req_type == 2'd0) || (req_type == 2'd3);
    eff      = wrap ? CW'(32'(req_count) % 32'(WIDTH)) : req_count;
    pass_ct  = '0;
    if (state == SHIFT)
      pass_ct = (rem > MAX_CT) ? BW'(WIDTH - 1) : rem[BW-1:0];
    rem_next = rem - CW'(pass_ct);
  end

  assign b_in       = acc;
  assign b_ct       = pass_ct;
  assign b_dir      = dir_q;
  assign b_type     = type_q;
  assign rsp_data   = acc;
  assign rsp_passes = passes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      rem       <= '0;
      passes    <= '0;
      dir_q     <= 1'b0;
      type_q    <= 2'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            acc       <= req_data;
            dir_q     <= req_left;
            type_q    <= req_type;
            rem       <= eff;
            passes    <= '0;
            req_ready <= 1'b0;
            if (eff != '0) begin
              state <= SHIFT;
            end else begin
              state     <= HOLD;
              rsp_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc    <= b_out;
          rem    <= rem_next;
          passes <= passes + CW'(1);
          if (rem_next == '0) begin
            state     <= HOLD;
            rsp_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_seq.sv
// Testbench for shift_seq: local barrel model, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_shift_seq;
  localparam int WIDTH = 32;
  localparam int CW    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_data = '0;
  logic [CW-1:0]    req_count = '0;
  logic             req_left = 1'b0;
  logic [1:0]       req_type = 2'd0;
  logic [WIDTH-1:0] b_in;
  logic [4:0]       b_ct;
  logic             b_dir;
  logic [1:0]       b_type;
  logic [WIDTH-1:0] b_out;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic [CW-1:0]    rsp_passes;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_seq #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_count(req_count), .req_left(req_left), .req_type(req_type),
    .b_in(b_in), .b_ct(b_ct), .b_dir(b_dir), .b_type(b_type), .b_out(b_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_passes(rsp_passes)
  );

  // single-pass barrel: 0/3 rotate, 1 logical, 2 arithmetic (left is logical)
  function automatic logic [31:0] barrel_f(input logic [31:0] a, input logic [4:0] ct,
                                           input logic left, input logic [1:0] typ);
    logic signed [31:0] s;
    s = a;
    if (typ == 2'd0 || typ == 2'd3)
      return left ? ((a << ct) | (ct == 0 ? 32'd0 : a >> (6'd32 - {1'b0, ct})))
                  : ((a >> ct) | (ct == 0 ? 32'd0 : a << (6'd32 - {1'b0, ct})));
    if (left) return a << ct;
    if (typ == 2'd2) return 32'(s >>> ct);
    return a >> ct;
  endfunction

  always_comb b_out = barrel_f(b_in, b_ct, b_dir, b_type);

  function automatic int ref_eff(input int cnt, input logic [1:0] typ);
    return (typ == 2'd0 || typ == 2'd3) ? cnt % 32 : cnt;
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] a, input int cnt,
                                             input logic left, input logic [1:0] typ);
    logic [31:0] r;
    logic signed [31:0] s;
    r = a;
    s = a;
    if (typ == 2'd0 || typ == 2'd3) begin
      for (int i = 0; i < cnt % 32; i++)
        r = left ? {r[30:0], r[31]} : {r[0], r[31:1]};
    end else if (left) begin
      r = (cnt >= 32) ? 32'd0 : a << cnt;
    end else if (typ == 2'd2) begin
      r = (cnt >= 32) ? {32{a[31]}} : 32'(s >>> cnt);
    end else begin
      r = (cnt >= 32) ? 32'd0 : a >> cnt;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level model: 0 idle, 1 passes in flight, 2 response held
  int          m_phase = 0;
  bit          m_ready = 1'b0;
  int          m_cnt = 0;
  int          m_rem = 0;
  logic [31:0] m_data = '0;
  int          m_passes = 0;

  always @(negedge rst_n) begin
    m_phase = 0;
    m_ready = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      case (m_phase)
        0: if (m_ready && req_valid) begin
             m_rem    = ref_eff(int'(req_count), req_type);
             m_data   = ref_result(req_data, int'(req_count), req_left, req_type);
             m_passes = (m_rem + 30) / 31;
             m_cnt    = m_passes;
             m_ready  = 1'b0;
             m_phase  = (m_cnt == 0) ? 2 : 1;
           end else begin
             m_ready = 1'b1;
           end
        1: begin
             m_rem = m_rem - ((m_rem > 31) ? 31 : m_rem);
             m_cnt--;
             if (m_cnt == 0) m_phase = 2;
           end
        default: if (rsp_ready) begin
             m_phase = 0;
             m_ready = 1'b1;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, rst_n && m_ready);
    chk("rsp_valid", rsp_valid, rst_n && m_phase == 2);
    chk("b_ct", b_ct, (rst_n && m_phase == 1) ? ((m_rem > 31) ? 31 : m_rem) : 0);
    if (rst_n && m_phase == 2) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_passes", rsp_passes, m_passes);
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk({nm, "_ready_timeout"}, req_ready, 1);
  endtask

  task automatic do_req(input string nm, input logic [31:0] a, input int cnt, input logic left,
                        input logic [1:0] typ, input logic [31:0] ed, input int ep,
                        input int hold_cycles);
    int n;
    rsp_ready = 1'b0;
    wait_ready(nm);
    req_valid = 1'b1;
    req_data  = a;
    req_count = CW'(cnt);
    req_left  = left;
    req_type  = typ;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = $urandom;
    req_count = CW'($urandom);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, ep);
    chk({nm, "_data"}, rsp_data, ed);
    chk({nm, "_passes"}, rsp_passes, ep);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      chk({nm, "_hold_data"}, rsp_data, ed);
      chk({nm, "_hold_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_ready_after"}, req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_b_ct", b_ct, 0);
    chk("reset_passes", rsp_passes, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    do_req("t1_left1",  32'd2,          1,  1'b1, 2'd1, 32'd4,          1, 0);
    do_req("t2_left40", 32'd1,          40, 1'b1, 2'd1, 32'd0,          2, 0);
    do_req("t3_arith",  32'h8000_0000,  35, 1'b0, 2'd2, 32'hFFFF_FFFF,  2, 0);
    do_req("t4_wrap",   32'd1,          33, 1'b1, 2'd0, 32'd2,          1, 0);
    do_req("t5_zero",   32'd24,         0,  1'b1, 2'd1, 32'd24,         0, 5);
    do_req("t6_rot_r",  32'h0000_0001,  1,  1'b0, 2'd3, 32'h8000_0000,  1, 0);

    wait_ready("t7");
    req_valid = 1'b1;
    req_data  = 32'h1234_5678;
    req_count = CW'(200);
    req_left  = 1'b1;
    req_type  = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_rst_rsp_valid", rsp_valid, 0);
    chk("t7_rst_req_ready", req_ready, 0);
    chk("t7_rst_b_ct", b_ct, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_req("t7_after", 32'd5, 3, 1'b1, 2'd1, 32'd40, 1, 0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = $urandom_range(0, 1);
      req_data  = $urandom;
      req_left  = $urandom_range(0, 1);
      req_type  = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      req_count = (r < 6) ? CW'($urandom_range(0, 40))
                : (r < 9) ? CW'($urandom_range(0, 100)) : CW'(255);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
